honk_arbiter: RTL

//   Shares the single board speaker between the two carts' honk requests from the operation encoder.
//   - Latches one-cycle honk pulses from both players.
//   - Grants the speaker to one cart at a time, round-robin when both are waiting.
//   - Plays a fixed-length square-wave tone per cart, then a silent gap.
//   - Active only while the game FSM reports RACING; leaving RACING aborts and flushes everything.

---
 rtl/honk_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/honk_arbiter.sv
// Shares one speaker between two carts' honk requests: latches pulses, grants round-robin,
// plays a per-cart square tone for HONK_CYCLES then a silent GAP_CYCLES gap; leaving RACING flushes all.
module honk_arbiter #(
  parameter int HONK_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 10_000_000,
  parameter int P1_TONE_DIV = 113_636,
  parameter int P2_TONE_DIV = 75_843
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] state,
  input  logic       p1_honk,
  input  logic       p2_honk,
  output logic [1:0] grant,
  output logic       audio_en,
  output logic       audio_out,
  output logic       busy
);

  localparam logic [2:0] RACING = 3'd4;
  localparam int TONE_MAX = (P1_TONE_DIV > P2_TONE_DIV) ? P1_TONE_DIV : P2_TONE_DIV;
  localparam int HW = $clog2(HONK_CYCLES + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TW = $clog2(TONE_MAX + 1);

  localparam logic [HW-1:0] PLAY_LAST = HW'(HONK_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TW-1:0] P1_LAST   = TW'(P1_TONE_DIV - 1);
  localparam logic [TW-1:0] P2_LAST   = TW'(P2_TONE_DIV - 1);

  typedef enum logic [1:0] {IDLE, PLAY, GAP} fsm_t;

  fsm_t          fsm;
  logic          pend_p1, pend_p2;
  logic          rr_p2;
  logic [HW-1:0] play_cnt;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] tone_cnt;

  logic          racing;
  logic          cand_p1, cand_p2, pick_p2;
  logic [TW-1:0] tone_last;

  assign racing    = (state == RACING);
  assign cand_p1   = pend_p1 | p1_honk;
  assign cand_p2   = pend_p2 | p2_honk;
  // P2 wins when it is the only candidate, or on a tie when the pointer favours it
  assign pick_p2   = cand_p2 & (~cand_p1 | rr_p2);
  assign tone_last = grant[1] ? P2_LAST : P1_LAST;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm       <= IDLE;
      pend_p1   <= 1'b0;
      pend_p2   <= 1'b0;
      rr_p2     <= 1'b0;
      play_cnt  <= '0;
      gap_cnt   <= '0;
      tone_cnt  <= '0;
      grant     <= 2'b00;
      audio_en  <= 1'b0;
      audio_out <= 1'b0;
      busy      <= 1'b0;
    end else if (!racing) begin
      fsm       <= IDLE;
      pend_p1   <= 1'b0;
      pend_p2   <= 1'b0;
      play_cnt  <= '0;
      gap_cnt   <= '0;
      tone_cnt  <= '0;
      grant     <= 2'b00;
      audio_en  <= 1'b0;
      audio_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          pend_p1 <= cand_p1;
          pend_p2 <= cand_p2;
          if (cand_p1 | cand_p2) begin
            fsm       <= PLAY;
            grant     <= pick_p2 ? 2'b10 : 2'b01;
            audio_en  <= 1'b1;
            audio_out <= 1'b1;
            busy      <= 1'b1;
            play_cnt  <= '0;
            tone_cnt  <= '0;
            rr_p2     <= ~pick_p2;
            if (pick_p2) pend_p2 <= 1'b0;
            else         pend_p1 <= 1'b0;
          end
        end
        PLAY: begin
          // the owner retriggering its own honk mid-tone is dropped
          pend_p1 <= pend_p1 | (p1_honk & ~grant[0]);
          pend_p2 <= pend_p2 | (p2_honk & ~grant[1]);
          if (play_cnt == PLAY_LAST) begin
            grant     <= 2'b00;
            audio_en  <= 1'b0;
            audio_out <= 1'b0;
            gap_cnt   <= '0;
            if (GAP_CYCLES == 0) begin
              fsm  <= IDLE;
              busy <= 1'b0;
            end else begin
              fsm  <= GAP;
            end
          end else begin
            play_cnt <= play_cnt + 1'b1;
            if (tone_cnt == tone_last) begin
              tone_cnt  <= '0;
              audio_out <= ~audio_out;
            end else begin
              tone_cnt <= tone_cnt + 1'b1;
            end
          end
        end
        GAP: begin
          pend_p1 <= pend_p1 | p1_honk;
          pend_p2 <= pend_p2 | p2_honk;
          if (gap_cnt == GAP_LAST) begin
            fsm  <= IDLE;
            busy <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
